// File: rtl/mem_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stream_reader_if
// Purpose  : Groups the control, memory-bus and output-stream signals of the
//            memory stream reader.
// Ports    : control  - start, base_addr, length, busy, done
//            memory   - mem_rd_nwr, mem_addr, mem_data_in, mem_data_out
//            stream   - m_valid, m_ready, m_data, m_last
//            master modport is the reader's view; slave is the environment's.
// Revision : 1.0  initial release
// ============================================================================
interface mem_stream_reader_if #(
  parameter int SIZE   = 32,
  parameter int ADDR_W = $clog2(SIZE),
  parameter int DATA_W = 32,
  parameter int LEN_W  = ADDR_W + 1
);
  // control
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  // memory bus
  logic              mem_rd_nwr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  // output stream
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    input  start, base_addr, length, mem_data_out, m_ready,
    output busy, done, mem_rd_nwr, mem_addr, mem_data_in, m_valid, m_data, m_last
  );

  modport slave (
    output start, base_addr, length, mem_data_out, m_ready,
    input  busy, done, mem_rd_nwr, mem_addr, mem_data_in, m_valid, m_data, m_last
  );
endinterface
`default_nettype wire

// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : mem_stream_reader
// Purpose  : Reads a contiguous (wrapping) address range from a single-port
//            synchronous memory with one-cycle read latency and presents the
//            words as a valid/ready stream with backpressure.
// Ports    : clk    - rising-edge clock (block and memory)
//            rst_n  - asynchronous active-low reset
//            bus_io - mem_stream_reader_if.master (control, memory, stream)
// Revision : 1.0  initial release
// ============================================================================
module mem_stream_reader #(
  parameter int SIZE   = 32,
  parameter int ADDR_W = $clog2(SIZE),
  parameter int DATA_W = 32,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  mem_stream_reader_if.master  bus_io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;        // next address to read
  logic [ADDR_W-1:0] hold_q;                // last address actually issued
  logic [LEN_W-1:0]  rd_rem_q, rd_rem_d;    // reads still to issue
  logic [LEN_W-1:0]  beat_rem_q, beat_rem_d;// beats still to hand out
  logic              inflight_q;            // read issued last cycle
  logic              done_q, done_d;

  // Two-entry output FIFO
  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic       pop;
  logic       issue;
  logic [1:0] occ;

  assign pop = (count_q != 2'd0) && bus_io.m_ready;
  // Slots already spoken for: stored words plus the word arriving this cycle.
  assign occ = count_q + {1'b0, inflight_q};
  // A slot freed by this cycle's pop can be reused by a read issued now,
  // because that data only lands in the FIFO on the following clock.
  assign issue = (state_q == ISSUE) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_rem_d   = rd_rem_q;
    beat_rem_d = beat_rem_q;
    done_d     = 1'b0;

    if (pop) begin
      beat_rem_d = beat_rem_q - LEN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus_io.start) begin
          if (bus_io.length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ISSUE;
            addr_d     = bus_io.base_addr;
            rd_rem_d   = bus_io.length;
            beat_rem_d = bus_io.length;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d   = (addr_q == ADDR_W'(SIZE - 1)) ? '0 : addr_q + ADDR_W'(1);
          rd_rem_d = rd_rem_q - LEN_W'(1);
          if (rd_rem_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (beat_rem_q == LEN_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      hold_q     <= '0;
      rd_rem_q   <= '0;
      beat_rem_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_rem_q   <= rd_rem_d;
      beat_rem_q <= beat_rem_d;
      inflight_q <= issue;
      done_q     <= done_d;
      if (issue) begin
        hold_q <= addr_q;
      end
      // Only the cycle after an issue carries data we asked for.
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= bus_io.mem_data_out;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({inflight_q, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus_io.busy        = (state_q != IDLE);
  assign bus_io.done        = done_q;
  assign bus_io.mem_rd_nwr  = 1'b1;
  assign bus_io.mem_data_in = '0;
  // Present the live address only while issuing so the bus stays quiet otherwise.
  assign bus_io.mem_addr    = issue ? addr_q : hold_q;
  assign bus_io.m_valid     = (count_q != 2'd0);
  assign bus_io.m_data      = fifo_q[rd_ptr_q];
  // The head is always the oldest outstanding beat, so it is the last one
  // exactly when a single beat remains.
  assign bus_io.m_last      = (count_q != 2'd0) && (beat_rem_q == LEN_W'(1));

endmodule
`default_nettype wire
